// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, signed (MULT) or unsigned (MULTU).
// The operands are reduced to magnitudes when they are accepted. One multiplier bit is
// consumed per cycle, and the sign is applied to the final sum at completion. dataOut
// holds the last product until the next completion.
module seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   dataOut
);

    typedef enum logic {IDLE, RUN} state_t;

    // The count value seen on the edge that finishes the last iteration
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t                state;
    logic [2*WIDTH-1:0]    multiplicand;
    logic [WIDTH-1:0]      multiplier;
    logic [2*WIDTH-1:0]    product;
    logic [CNT_W-1:0]      count;
    logic                  neg;
    logic [2*WIDTH-1:0]    product_next;

    // Magnitude of an operand. -2^(W-1) maps to 2^(W-1), which fits as an unsigned W-bit value
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        magnitude = (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    // Reapply the sign of the result to the unsigned product
    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p, input logic n);
        apply_sign = n ? (~p + (2*WIDTH)'(1)) : p;
    endfunction

    // Partial-product accumulation for the current multiplier bit
    always_comb begin
        product_next = product;
        if (multiplier[0]) begin
            product_next = product + multiplicand;
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            multiplicand <= '0;
            multiplier   <= '0;
            product      <= '0;
            count        <= '0;
            neg          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            dataOut      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        multiplicand <= {{WIDTH{1'b0}}, magnitude(dataA, signed_mode)};
                        multiplier   <= magnitude(dataB, signed_mode);
                        neg          <= signed_mode & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
                        product      <= '0;
                        count        <= '0;
                        busy         <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    product      <= product_next;
                    multiplicand <= multiplicand << 1;
                    multiplier   <= multiplier >> 1;
                    count        <= count + CNT_W'(1);
                    if (count == LAST_CNT) begin
                        dataOut <= apply_sign(product_next, neg);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=32 and WIDTH=8.
module tb_seq_multiplier;

    logic        clk;
    logic        reset;

    logic        start32, sm32, busy32, done32;
    logic [31:0] a32, b32;
    logic [63:0] out32;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] out8;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [63:0] exp;
        int          edge_n;
    } item32_t;

    typedef struct {
        logic [15:0] exp;
        int          edge_n;
    } item8_t;

    item32_t q32[$];
    item8_t  q8[$];
    logic [63:0] held32 = '0;
    logic [15:0] held8  = '0;

    seq_multiplier #(.WIDTH(32), .CNT_W(7)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .signed_mode(sm32),
        .dataA(a32), .dataB(b32), .busy(busy32), .done(done32), .dataOut(out32)
    );

    seq_multiplier #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
        .dataA(a8), .dataB(b8), .busy(busy8), .done(done8), .dataOut(out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference products from plain integer multiplication
    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic signed [15:0] sa, sb;
        if (s) begin
            sa = {{8{a[7]}}, a};
            sb = {{8{b[7]}}, b};
            return sa * sb;
        end
        return {8'b0, a} * {8'b0, b};
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 4))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h80;
            3: return 8'h7F;
            default: return 8'($urandom);
        endcase
    endfunction

    // Monitor: pop and compare on each completion; otherwise dataOut must hold
    always @(negedge clk) begin
        if (done32) begin
            if (q32.size() == 0) begin
                chk("unexpected_done32", 128'(done32), 128'(1'b0));
            end else begin
                item32_t it;
                it = q32.pop_front();
                chk("product32", 128'(out32), 128'(it.exp));
                chk("latency32", 128'(cyc), 128'(it.edge_n + 32));
                chk("busy_at_done32", 128'(busy32), 128'(1'b0));
                held32 = it.exp;
            end
        end else begin
            chk("hold32", 128'(out32), 128'(held32));
            chk("busy32", 128'(busy32), 128'(q32.size() != 0));
        end
    end

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                chk("unexpected_done8", 128'(done8), 128'(1'b0));
            end else begin
                item8_t it;
                it = q8.pop_front();
                chk("product8", 128'(out8), 128'(it.exp));
                chk("latency8", 128'(cyc), 128'(it.edge_n + 8));
                chk("busy_at_done8", 128'(busy8), 128'(1'b0));
                held8 = it.exp;
            end
        end else begin
            chk("hold8", 128'(out8), 128'(held8));
            chk("busy8", 128'(busy8), 128'(q8.size() != 0));
        end
    end

    // Advance to just after the next falling edge
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Present a one-cycle start pulse; push the expected product if it will be accepted
    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic s);
        item32_t it;
        start32 = 1'b1;
        a32 = a;
        b32 = b;
        sm32 = s;
        if (!busy32) begin
            it.exp = ref32(a, b, s);
            it.edge_n = cyc + 1;
            q32.push_back(it);
        end
        step();
        start32 = 1'b0;
        a32 = $urandom;
        b32 = $urandom;
        sm32 = 1'($urandom);
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s);
        item8_t it;
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        sm8 = s;
        if (!busy8) begin
            it.exp = ref8(a, b, s);
            it.edge_n = cyc + 1;
            q8.push_back(it);
        end
        step();
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        sm8 = 1'($urandom);
    endtask

    task automatic wait_idle32(input int maxc);
        int n = 0;
        while ((q32.size() != 0 || busy32) && n < maxc) begin
            step();
            n++;
        end
        chk("idle_timeout32", 128'(q32.size() == 0 && !busy32), 128'(1'b1));
    endtask

    task automatic wait_idle8(input int maxc);
        int n = 0;
        while ((q8.size() != 0 || busy8) && n < maxc) begin
            step();
            n++;
        end
        chk("idle_timeout8", 128'(q8.size() == 0 && !busy8), 128'(1'b1));
    endtask

    initial begin
        reset = 1'b0;
        start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
        start8 = 1'b0;  sm8 = 1'b0;  a8 = '0;  b8 = '0;
        #1 reset = 1'b1;
        step();
        step();
        chk("rst_busy", 128'(busy32), 128'(1'b0));
        chk("rst_done", 128'(done32), 128'(1'b0));
        chk("rst_out", 128'(out32), 128'(0));
        reset = 1'b0;
        step();

        // Directed corner products
        issue32(32'd3, 32'd5, 1'b0);
        wait_idle32(60);
        chk("3x5", 128'(out32), 128'(64'hF));
        issue32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        wait_idle32(60);
        chk("ffff_u", 128'(out32), 128'(64'hFFFFFFFE00000001));
        issue32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_idle32(60);
        chk("m1xm1_s", 128'(out32), 128'(64'h1));
        issue32(32'hFFFFFFFD, 32'd5, 1'b1);
        wait_idle32(60);
        chk("m3x5_s", 128'(out32), 128'(64'hFFFFFFFFFFFFFFF1));
        issue32(32'h80000000, 32'h80000000, 1'b1);
        wait_idle32(60);
        chk("min_x_min_s", 128'(out32), 128'(64'h4000000000000000));

        // Start while busy is ignored; start in the done cycle is accepted
        issue32(32'd7, 32'd6, 1'b0);
        repeat (9) step();
        issue32(32'd9, 32'd9, 1'b0);
        begin
            int n = 0;
            while (!done32 && n < 60) begin
                step();
                n++;
            end
            chk("done_seen", 128'(done32), 128'(1'b1));
        end
        chk("7x6", 128'(out32), 128'(64'd42));
        issue32(32'd9, 32'd9, 1'b0);
        wait_idle32(60);
        chk("9x9", 128'(out32), 128'(64'd81));

        // Randomised mix of idle gaps, back-to-back starts and starts while busy
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) issue32(pick32(), pick32(), 1'($urandom));
            else step();
        end
        wait_idle32(100);

        // Reset in the middle of an operation
        issue32(32'd100, 32'd100, 1'b0);
        repeat (14) step();
        #1;
        reset = 1'b1;
        q32.delete();
        held32 = '0;
        #1;
        chk("midrst_busy", 128'(busy32), 128'(1'b0));
        chk("midrst_done", 128'(done32), 128'(1'b0));
        chk("midrst_out", 128'(out32), 128'(0));
        step();
        reset = 1'b0;
        repeat (40) step();
        issue32(32'd2, 32'd2, 1'b0);
        wait_idle32(60);
        chk("2x2_after_rst", 128'(out32), 128'(64'd4));

        // Narrow instance
        issue8(8'h80, 8'h80, 1'b1);
        wait_idle8(30);
        chk("w8_min_x_min", 128'(out8), 128'(16'h4000));
        issue8(8'hFF, 8'hFF, 1'b0);
        wait_idle8(30);
        chk("w8_ff_u", 128'(out8), 128'(16'hFE01));
        repeat (300) begin
            if ($urandom_range(0, 2) == 0) issue8(pick8(), pick8(), 1'($urandom));
            else step();
        end
        wait_idle8(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised iterative shift-add multiplier, successor to the fixed 32-bit MULTU unit in the EX stage. It supports both signed (MULT) and unsigned (MULTU) operation at any operand width, with an explicit start/busy/done handshake in place of a free-running counter. The product is held stable until the next completion, so the HI/LO write-back logic can sample it any time after done.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits; legal range 4..64
CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; accepted only when busy=0
signed_mode  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
dataA  input  WIDTH  multiplicand; sampled with start
dataB  input  WIDTH  multiplier; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when a new product is valid
dataOut  output  2*WIDTH  product; dataOut[2W-1:W] = HI, dataOut[W-1:0] = LO

Behaviour:
- Reset (asynchronous, any state): busy=0, done=0, dataOut=0, counter=0, internal registers=0, state=IDLE. Reset during RUN abandons the operation; no done pulse follows.
- States: IDLE, RUN.
- IDLE, start=1 at edge k:
  - capture magA=|dataA| and magB=|dataB| when signed_mode=1, else the raw values;
  - capture neg = signed_mode & (dataA[W-1] ^ dataB[W-1]);
  - Multiplicand = {W'b0, magA}, Multiplier = magB, Product = 0, count = 0, busy=1, go to RUN.
- RUN, each edge:
  - if Multiplier[0], Product += Multiplicand;
  - Multiplicand <<= 1, Multiplier >>= 1, count += 1.
- On the edge where count reaches WIDTH (edge k+WIDTH):
  - dataOut = neg ? two's-complement negation of the final Product : final Product;
  - busy=0, done=1 for exactly one cycle, go to IDLE.
- Latency: start sampled at edge k, result and done visible after edge k+WIDTH (WIDTH cycles).
- Absolute value of the most negative input (-2^(W-1)) is 2^(W-1). It is treated as an unsigned W-bit magnitude and is exact.
- Product arithmetic is 2*WIDTH bits unsigned; no overflow is possible.
- start while busy=1: ignored; operands are not re-sampled; the in-flight result is unaffected.
- start in the cycle done=1: busy is already 0, so start is accepted at that edge. Back-to-back operations run with no bubble, and dataOut holds the previous result until the new completion.
- dataOut changes only at a completion edge or on reset. done is never asserted without a dataOut update.
- signed_mode, dataA and dataB are don't-care except in the cycle start is accepted.

Test Plan:
- WIDTH=32, unsigned, dataA=3, dataB=5, start at edge k -> busy high for edges k..k+31; done pulses after edge k+32; dataOut=0x0000000000000000F.
- Unsigned 0xFFFFFFFF*0xFFFFFFFF -> dataOut=0xFFFFFFFE00000001. The same operands with signed_mode=1 (-1*-1) -> dataOut=0x0000000000000001.
- Signed -3*5 (0xFFFFFFFD, 5) -> dataOut=0xFFFFFFFFFFFFFFF1. Signed 0x80000000*0x80000000 -> dataOut=0x4000000000000000.
- Start 7*6; pulse start again with 9*9 at edge k+10 -> second start ignored; result 42 (0x2A) at edge k+32. Then start 9*9 in the done cycle -> accepted; 81 at edge k+64; dataOut holds 42 in between.
- Assert reset at edge k+15 of a running 100*100 -> busy=0, done=0, dataOut=0 immediately; no done pulse afterwards; next start 2*2 -> 4 after 32 cycles.
- WIDTH=8, signed -128*-128 -> dataOut=16'h4000 after 8 cycles; unsigned 255*255 -> 16'hFE01.
